// File: rtl/rpn_eval_sequencer.sv
`default_nettype none
// ============================================================================
// rpn_eval_sequencer : postfix token evaluator driving a shared ALU
// Revision 1.0
// ============================================================================
module rpn_eval_sequencer #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             tok_valid_i,
   output logic             tok_ready_o,
   input  logic             tok_is_op_i,
   input  logic [WIDTH-1:0] tok_data_i,
   output logic             alu_req_o,
   input  logic             alu_ack_i,
   output logic [1:0]       alu_op_o,
   output logic [WIDTH-1:0] alu_a_o,
   output logic [WIDTH-1:0] alu_b_o,
   input  logic [WIDTH-1:0] alu_result_i,
   output logic [WIDTH-1:0] result_o,
   output logic             done_o,
   output logic [1:0]       error_o,
   output logic             busy_o
);

   localparam int SPW = $clog2(DEPTH + 1);
   localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] C_ERR_OVF  = 2'b01;
   localparam logic [1:0] C_ERR_UNF  = 2'b10;
   localparam logic [1:0] C_ERR_END  = 2'b11;
   localparam logic [1:0] C_OP_END   = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_EXEC  = 3'd2,
      S_DONE  = 3'd3,
      S_ERR   = 3'd4
   } state_t;

   state_t           state_q;
   logic [SPW-1:0]   sp_q;
   logic [WIDTH-1:0] stack_q [DEPTH];
   logic             tok_ready_q, alu_req_q, done_q, busy_q;
   logic [1:0]       alu_op_q, error_q;
   logic [WIDTH-1:0] alu_a_q, alu_b_q, result_q;

   // Stack slot addresses; only used when sp_q makes them in range.
   logic [AW-1:0] w_idx_push, w_idx_top, w_idx_nos;
   logic          w_full, w_has_two, w_has_one;

   assign w_idx_push = AW'(sp_q);
   assign w_idx_top  = AW'(sp_q - SPW'(1));
   assign w_idx_nos  = AW'(sp_q - SPW'(2));
   assign w_full     = (sp_q == SPW'(DEPTH));
   assign w_has_two  = (sp_q >= SPW'(2));
   assign w_has_one  = (sp_q == SPW'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         sp_q        <= '0;
         tok_ready_q <= 1'b0;
         alu_req_q   <= 1'b0;
         alu_op_q    <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         result_q    <= '0;
         done_q      <= 1'b0;
         error_q     <= '0;
         busy_q      <= 1'b0;
         for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
               if (start_i) begin
                  state_q     <= S_FETCH;
                  sp_q        <= '0;
                  done_q      <= 1'b0;
                  error_q     <= '0;
                  tok_ready_q <= 1'b1;
                  busy_q      <= 1'b1;
               end
            end
            S_FETCH: begin
               if (tok_valid_i) begin
                  if (!tok_is_op_i) begin
                     if (w_full) begin
                        state_q     <= S_ERR;
                        error_q     <= C_ERR_OVF;
                        tok_ready_q <= 1'b0;
                        busy_q      <= 1'b0;
                     end else begin
                        stack_q[w_idx_push] <= tok_data_i;
                        sp_q                <= sp_q + SPW'(1);
                     end
                  end else if (tok_data_i[1:0] == C_OP_END) begin
                     tok_ready_q <= 1'b0;
                     busy_q      <= 1'b0;
                     if (w_has_one) begin
                        state_q  <= S_DONE;
                        result_q <= stack_q[0];
                        done_q   <= 1'b1;
                     end else begin
                        state_q  <= S_ERR;
                        error_q  <= C_ERR_END;
                     end
                  end else if (w_has_two) begin
                     state_q     <= S_EXEC;
                     alu_a_q     <= stack_q[w_idx_nos];
                     alu_b_q     <= stack_q[w_idx_top];
                     alu_op_q    <= tok_data_i[1:0];
                     alu_req_q   <= 1'b1;
                     tok_ready_q <= 1'b0;
                  end else begin
                     state_q     <= S_ERR;
                     error_q     <= C_ERR_UNF;
                     tok_ready_q <= 1'b0;
                     busy_q      <= 1'b0;
                  end
               end
            end
            S_EXEC: begin
               // The result replaces the left operand; the right one is popped.
               if (alu_ack_i) begin
                  stack_q[w_idx_nos] <= alu_result_i;
                  sp_q               <= sp_q - SPW'(1);
                  alu_req_q          <= 1'b0;
                  tok_ready_q        <= 1'b1;
                  state_q            <= S_FETCH;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               tok_ready_q <= 1'b0;
               alu_req_q   <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign tok_ready_o = tok_ready_q;
   assign alu_req_o   = alu_req_q;
   assign alu_op_o    = alu_op_q;
   assign alu_a_o     = alu_a_q;
   assign alu_b_o     = alu_b_q;
   assign result_o    = result_q;
   assign done_o      = done_q;
   assign error_o     = error_q;
   assign busy_o      = busy_q;

endmodule
`default_nettype wire
